// File: rtl/dffram_adapter_pkg.sv
// Shared types and constants for the byte-wide front-end of the 2R1W DFF RAM.
package dffram_adapter_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR_LO = 3'd1,
    WR_HI = 3'd2,
    RD_LO = 3'd3,
    RD_HI = 3'd4,
    RSP   = 3'd5
  } state_e;

  localparam int DEPTH_DEFAULT  = 24;
  localparam int NIB_W          = 4;
  localparam int BYTE_W         = 2 * NIB_W;
  localparam int ADDR_W_DEFAULT = 5;

endpackage

// File: rtl/dffram_byte_adapter.sv
// Byte command front-end: splits each byte read/write into two nibble accesses
// on RAM port A and returns one response per command.
module dffram_byte_adapter
  import dffram_adapter_pkg::*;
#(
  parameter int ADDRWIDTH = ADDR_W_DEFAULT,
  parameter int NIBWIDTH  = NIB_W,
  parameter int DEPTH     = DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Handshake: a transfer happens on any rising edge where valid && ready;
  // valid holds its payload until then, ready never depends on valid.
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDRWIDTH-1:0]  cmd_addr,
  input  logic [2*NIBWIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*NIBWIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDRWIDTH-1:0]  ram_addr,
  output logic                  ram_lohi,
  output logic [NIBWIDTH-1:0]   ram_wdata,
  output logic                  ram_w_en,
  input  logic [NIBWIDTH-1:0]   ram_rdata,
  output logic [2:0]            dbg_state
);

  state_e                state, state_nxt;
  logic [ADDRWIDTH-1:0]  addr_q;
  logic [2*NIBWIDTH-1:0] wdata_q;
  logic [2*NIBWIDTH-1:0] rdata_q;
  logic                  write_q;
  logic                  err_q;
  logic                  accept;
  logic                  out_of_range;

  assign out_of_range = 32'(cmd_addr) >= 32'(DEPTH);
  // Reset qualifies ready so nothing is offered while the block is held in reset.
  assign cmd_ready    = rst_n && (state == IDLE);
  assign accept       = cmd_valid && cmd_ready;

  assign ram_addr  = addr_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        write_q <= cmd_write;
        err_q   <= out_of_range;
        rdata_q <= '0;
      end
      if (state == RD_LO) rdata_q[NIBWIDTH-1:0] <= ram_rdata;
      if (state == RD_HI) rdata_q[2*NIBWIDTH-1:NIBWIDTH] <= ram_rdata;
      if (state == RSP && rsp_ready) begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  // Write enable is also qualified by rst_n so a reset landing in WR_HI
  // leaves the high nibble untouched at the reset edge.
  always_comb begin
    state_nxt = state;
    rsp_valid = 1'b0;
    ram_w_en  = 1'b0;
    ram_lohi  = 1'b0;
    ram_wdata = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (out_of_range)   state_nxt = RSP;
          else if (cmd_write) state_nxt = WR_LO;
          else                state_nxt = RD_LO;
        end
      end
      WR_LO: begin
        ram_w_en  = rst_n && write_q;
        ram_lohi  = 1'b1;
        ram_wdata = wdata_q[NIBWIDTH-1:0];
        state_nxt = WR_HI;
      end
      WR_HI: begin
        ram_w_en  = rst_n && write_q;
        ram_lohi  = 1'b0;
        ram_wdata = wdata_q[2*NIBWIDTH-1:NIBWIDTH];
        state_nxt = RSP;
      end
      RD_LO: begin
        ram_lohi  = 1'b0;
        state_nxt = RD_HI;
      end
      RD_HI: begin
        ram_lohi  = 1'b1;
        state_nxt = RSP;
      end
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dffram_byte_adapter.sv
// Directed bench for dffram_byte_adapter with a nibble-addressed RAM model on port A.
module tb_dffram_byte_adapter;
  import dffram_adapter_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [4:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [4:0] ram_addr;
  logic       ram_lohi;
  logic [3:0] ram_wdata;
  logic       ram_w_en;
  logic [3:0] ram_rdata;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // RAM model and write log
  logic       tb_init;
  logic [7:0] mem[32];
  int         wen_count = 0;
  logic       wlog_lohi[64];
  logic [3:0] wlog_data[64];
  logic [4:0] wlog_addr[64];

  dffram_byte_adapter dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_addr(ram_addr), .ram_lohi(ram_lohi), .ram_wdata(ram_wdata), .ram_w_en(ram_w_en),
    .ram_rdata(ram_rdata), .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  assign ram_rdata = ram_lohi ? mem[ram_addr][7:4] : mem[ram_addr][3:0];

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
      mem[0] <= 8'h5A;
    end else if (ram_w_en) begin
      if (ram_lohi) mem[ram_addr][3:0] <= ram_wdata;
      else          mem[ram_addr][7:4] <= ram_wdata;
      if (wen_count < 64) begin
        wlog_lohi[wen_count] <= ram_lohi;
        wlog_data[wen_count] <= ram_wdata;
        wlog_addr[wen_count] <= ram_addr;
      end
      wen_count <= wen_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Issue one command with rsp_ready high; returns response fields and latency
  // counted in cycles after the accept edge.
  task automatic do_cmd(input logic w, input logic [4:0] a, input logic [7:0] d,
                        output logic [7:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; rsp_ready = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("cmd_accept", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  initial begin
    logic [7:0] rd;
    logic       er;
    int         lat, n, w0, k, t, last, nrsp;
    logic       upd;

    // Reset
    rst_n = 1'b0; tb_init = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_ram_w_en",  32'(ram_w_en),  32'd0);
    chk("rst_ram_lohi",  32'(ram_lohi),  32'd0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("rst_ram_addr",  32'(ram_addr),  32'd0);
    chk("rst_state",     32'(dbg_state), 32'(IDLE));
    tb_init = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    // Write 0xA5 to address 3, then read it back
    w0 = wen_count;
    do_cmd(1'b1, 5'd3, 8'hA5, rd, er, lat);
    chk("wr_lat",   32'(lat), 32'd3);
    chk("wr_err",   32'(er),  32'd0);
    chk("wr_rdata", 32'(rd),  32'd0);
    chk("wr_wen_count", 32'(wen_count - w0), 32'd2);
    chk("wr_lo_lohi", 32'(wlog_lohi[w0]),   32'd1);
    chk("wr_lo_data", 32'(wlog_data[w0]),   32'h5);
    chk("wr_hi_lohi", 32'(wlog_lohi[w0+1]), 32'd0);
    chk("wr_hi_data", 32'(wlog_data[w0+1]), 32'hA);
    chk("wr_addr",    32'(wlog_addr[w0]),   32'd3);
    exp_q.push_back(8'hA5);
    do_cmd(1'b0, 5'd3, 8'h00, rd, er, lat);
    chk("rd3_data", 32'(rd), 32'(exp_q.pop_front()));
    chk("rd3_err",  32'(er),  32'd0);
    chk("rd3_lat",  32'(lat), 32'd3);

    // Out-of-range write, then address 0 keeps its prior value
    w0 = wen_count;
    do_cmd(1'b1, 5'd24, 8'h3C, rd, er, lat);
    chk("oor_lat",   32'(lat), 32'd1);
    chk("oor_err",   32'(er),  32'd1);
    chk("oor_rdata", 32'(rd),  32'd0);
    @(negedge clk);
    chk("oor_no_wen", 32'(wen_count - w0), 32'd0);
    do_cmd(1'b0, 5'd0, 8'h00, rd, er, lat);
    chk("rd0_data", 32'(rd), 32'h5A);
    chk("rd0_err",  32'(er), 32'd0);

    // Backpressure with a queued command behind the response
    @(negedge clk);
    rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 5'd3;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("bp_accept", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_addr = 5'd0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("bp_lat",   32'(lat), 32'd3);
    chk("bp_rdata", 32'(rsp_rdata), 32'hA5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_hold", 32'(rsp_valid), 32'd1);
      chk("bp_rdata_hold", 32'(rsp_rdata), 32'hA5);
      chk("bp_cmd_ready",  32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_released_valid", 32'(rsp_valid), 32'd0);
    chk("bp_released_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    chk("bp_q_lat",   32'(lat), 32'd3);
    chk("bp_q_rdata", 32'(rsp_rdata), 32'h5A);

    // Back-to-back: 4 writes then 4 reads with cmd_valid held high
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h44);
    @(negedge clk);
    rsp_ready = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd0; cmd_wdata = 8'h11;
    k = 0; t = 0; last = 0; nrsp = 0; upd = 1'b0;
    while ((k < 8 || nrsp < 8) && t < 200) begin
      if (rsp_valid) begin
        if (nrsp < 4) chk("b2b_wr_err", 32'(rsp_err), 32'd0);
        else          chk("b2b_rd_data", 32'(rsp_rdata), 32'(exp_q.pop_front()));
        nrsp++;
      end
      if (k < 8 && cmd_ready) begin
        if (k > 0) chk("b2b_gap", 32'(t - last), 32'd4);
        last = t; k++; upd = 1'b1;
      end
      @(negedge clk); t++;
      if (upd) begin
        if (k < 8) begin
          cmd_write = (k < 4);
          cmd_addr  = 5'(k % 4);
          cmd_wdata = 8'((k % 4 + 1) * 17);
        end else begin
          cmd_valid = 1'b0;
        end
        upd = 1'b0;
      end
    end
    chk("b2b_cmds", 32'(k),    32'd8);
    chk("b2b_rsps", 32'(nrsp), 32'd8);

    // Reset landing in WR_HI
    do_cmd(1'b1, 5'd7, 8'h0F, rd, er, lat);
    chk("pre_rst_wr_lat", 32'(lat), 32'd3);
    @(negedge clk);
    w0 = wen_count;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 5'd7; cmd_wdata = 8'hF0;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rst_mid_wrlo", 32'(dbg_state), 32'(WR_LO));
    @(negedge clk);
    chk("rst_mid_wrhi", 32'(dbg_state), 32'(WR_HI));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ready_now", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_mid_ready", 32'(cmd_ready), 32'd0);
      chk("rst_mid_valid", 32'(rsp_valid), 32'd0);
      chk("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    end
    chk("rst_mid_wen_count", 32'(wen_count - w0), 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    do_cmd(1'b0, 5'd7, 8'h00, rd, er, lat);
    chk("rst_rd7_data", 32'(rd), 32'h00);
    chk("rst_rd7_err",  32'(er), 32'd0);

    // Range boundary
    do_cmd(1'b1, 5'd23, 8'h7E, rd, er, lat);
    do_cmd(1'b0, 5'd23, 8'h00, rd, er, lat);
    chk("rd23_data", 32'(rd),  32'h7E);
    chk("rd23_err",  32'(er),  32'd0);
    chk("rd23_lat",  32'(lat), 32'd3);
    do_cmd(1'b0, 5'd31, 8'h00, rd, er, lat);
    chk("rd31_data", 32'(rd),  32'h00);
    chk("rd31_err",  32'(er),  32'd1);
    chk("rd31_lat",  32'(lat), 32'd1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dffram_byte_adapter.md
# dffram_byte_adapter

Byte-wide command front-end for the 2R1W DFF RAM. It accepts byte read and write commands over a valid/ready handshake and turns each one into two nibble accesses on the RAM's port A. It assembles read nibbles back into a byte and returns one response per command. It sits directly upstream of the RAM and owns all lo/hi nibble sequencing and range checking.

## Interface
Parameters:
- ADDRWIDTH, default 5: byte address width.
- NIBWIDTH, default 4: RAM port data width.
- DEPTH, default 24: number of implemented byte locations; addresses at or above DEPTH are out of range.

Ports (reset `rst_n`, synchronous, active-low; clock `clk`):
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  adapter accepts a command this cycle.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDRWIDTH  byte address.
- cmd_wdata  in  2*NIBWIDTH  write byte.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  2*NIBWIDTH  read byte; 0 for writes and errors.
- rsp_err  out  1  command addressed an out-of-range location.
- ram_addr  out  ADDRWIDTH  RAM address: {addrhi, addr_a}.
- ram_lohi  out  1  RAM nibble select.
- ram_wdata  out  NIBWIDTH  RAM write nibble.
- ram_w_en  out  1  RAM write enable.
- ram_rdata  in  NIBWIDTH  RAM port A read nibble; unbuffered, valid in the same cycle.

## Operation
- FSM states: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, register cmd_addr, cmd_wdata and cmd_write.
  - Next state: RSP with err=1 if cmd_addr>=DEPTH; otherwise WR_LO for a write, RD_LO for a read.
- WR_LO: ram_w_en=1, ram_lohi=1, ram_wdata=wdata[3:0]. Next state WR_HI.
- WR_HI: ram_w_en=1, ram_lohi=0, ram_wdata=wdata[7:4]. Next state RSP.
- RD_LO: ram_lohi=0. At the clock edge, capture ram_rdata into rdata[3:0]. Next state RD_HI.
- RD_HI: ram_lohi=1. At the clock edge, capture ram_rdata into rdata[7:4]. Next state RSP.
- RSP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready, go to IDLE and clear err and rdata.
- ram_addr equals the registered address in every non-IDLE state and holds its last value in IDLE.
- ram_w_en is asserted only in WR_LO and WR_HI. It is never asserted for an out-of-range address.
- ram_lohi convention, matched to the RAM:
  - Writes: 1 selects bits [3:0], 0 selects bits [7:4].
  - Reads: 0 returns bits [3:0], 1 returns bits [7:4].
- Out-of-range read: rsp_rdata=0x00, rsp_err=1. No RAM write is issued.

## Timing
- Reset while rst_n=0, at the next edge:
  - state=IDLE.
  - cmd_ready=0 during reset, 1 from the first cycle after release.
  - rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - ram_w_en=0, ram_lohi=0, ram_wdata=0, ram_addr=0.
- Accept edge = cycle 0. Valid command: rsp_valid at cycle 3. Error: rsp_valid at cycle 1.
- Peak throughput is one valid command per 4 cycles when rsp_ready=1. cmd_ready=0 in every state except IDLE.
- The response persists indefinitely while rsp_ready=0; no new command is accepted until it is taken.
- All RAM-side outputs are Moore decodes of state plus registered fields. There are no combinational paths from cmd_* or rsp_ready.
- Reset mid-operation:
  - Abort immediately; no response is produced.
  - Reset during WR_HI leaves the low nibble written and the high nibble stale. This is the defined behaviour.
- Address wrap: none. The address is used verbatim and range-checked against DEPTH.

## Structure
- Package dffram_adapter_pkg holds:
  - the state enum (IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RSP);
  - localparam DEPTH_DEFAULT=24;
  - nibble and byte width constants.
- Single module, no sub-module. FSM, command register and read assembly register live together.

## Test plan
- Write then read: write 0xA5 to address 3, read address 3.
  - Write: ram_w_en high 2 cycles, first with lohi=1/wdata=5, then lohi=0/wdata=A.
  - Read: rsp_rdata=0xA5, rsp_err=0, rsp_valid exactly 3 cycles after accept.
- Out-of-range write: write 0x3C to address 24 -> rsp_err=1 at cycle 1, ram_w_en never high. A following read of address 0 returns its prior value unchanged.
- Backpressure: read with rsp_ready held low 5 cycles.
  - rsp_valid and rsp_rdata are stable throughout.
  - cmd_ready=0 throughout; a queued cmd_valid is accepted only after the response handshake.
- Back-to-back: cmd_valid held high with 4 writes to addresses 0-3 (0x11, 0x22, 0x33, 0x44), then 4 reads.
  - Accept edges are 4 cycles apart.
  - Read data matches the written values.
- Reset in WR_HI: write 0xF0 over existing 0x0F, pulse rst_n low during WR_HI.
  - No response; cmd_ready=0 during reset.
  - After release, reading that address returns 0x00: low nibble newly written, high nibble still stale.
- Read boundary: read address 23 after writing 0x7E there -> 0x7E, err=0. Read address 31 -> 0x00, err=1.
